// File: rtl/boot_rom_copier.sv
//==============================================================================
// Module   : boot_rom_copier
// Desc     : Loads a header-described program image from boot ROM into
//            instruction RAM, then releases the core. Define BOOT_CHECKSUM_EN
//            to verify a trailing XOR checksum word before release.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module boot_rom_copier #(
    parameter int          ROM_ADDR_WIDTH     = 12,
    parameter int          INSTR_RAM_SIZE     = 32768,
    parameter logic [31:0] INSTR_BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FALLBACK_BOOT_ADDR = 32'h0000_8000,
    parameter logic [15:0] BOOT_MAGIC         = 16'hB007,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    output logic                      rom_en_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i,
    output logic                      instr_req_o,
    output logic                      instr_we_o,
    output logic [31:0]               instr_addr_o,
    output logic [31:0]               instr_wdata_o,
    output logic [3:0]                instr_be_o,
    input  logic                      instr_gnt_i,
    output logic                      fetch_enable_o,
    output logic [31:0]               boot_addr_o,
    output logic                      busy_o,
    output logic                      error_o,
    output logic [15:0]               words_copied_o
);

    localparam int c_RAM_WORDS = INSTR_RAM_SIZE / 4;
    localparam int c_ROM_WORDS = (1 << ROM_ADDR_WIDTH) - 1;
    localparam int c_MAX_BASE  = (c_RAM_WORDS < c_ROM_WORDS) ? c_RAM_WORDS : c_ROM_WORDS;
`ifdef BOOT_CHECKSUM_EN
    // One ROM word is reserved for the checksum after the image.
    localparam int c_MAX_WORDS = c_MAX_BASE - 1;
`else
    localparam int c_MAX_WORDS = c_MAX_BASE;
`endif
    localparam logic [ROM_ADDR_WIDTH-1:0] c_MAX_N = ROM_ADDR_WIDTH'(c_MAX_WORDS);
    localparam logic [ROM_ADDR_WIDTH-1:0] c_K_ONE = ROM_ADDR_WIDTH'(1);

    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_HDR_RD  = 4'd1;
    localparam logic [3:0] c_ST_HDR_CAP = 4'd2;
    localparam logic [3:0] c_ST_HDR_CHK = 4'd3;
    localparam logic [3:0] c_ST_RD      = 4'd4;
    localparam logic [3:0] c_ST_CAP     = 4'd5;
    localparam logic [3:0] c_ST_WR      = 4'd6;
    localparam logic [3:0] c_ST_DONE    = 4'd7;
    localparam logic [3:0] c_ST_ERROR   = 4'd8;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [3:0] c_ST_CK_RD   = 4'd9;
    localparam logic [3:0] c_ST_CK_CAP  = 4'd10;
    localparam logic [3:0] c_ST_CK_CHK  = 4'd11;
`endif

    logic [3:0]                r_state;
    logic [31:0]               r_hdr;
    logic [31:0]               r_data;
    logic [ROM_ADDR_WIDTH-1:0] r_k;
    logic [ROM_ADDR_WIDTH-1:0] r_n;
    logic [15:0]               r_words;
    logic                      r_fetch_en;
    logic                      r_err;
    logic [31:0]               r_boot_addr;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]               r_csum;
`endif

    logic [ROM_ADDR_WIDTH-1:0] w_k_next;
    logic [15:0]               w_hdr_len;
    logic                      w_hdr_bad;
    logic [ROM_ADDR_WIDTH-1:0] w_len_clamped;

    assign w_k_next      = r_k + c_K_ONE;
    assign w_hdr_len     = r_hdr[15:0];
    assign w_hdr_bad     = (r_hdr[31:16] != BOOT_MAGIC) || (w_hdr_len == 16'd0);
    assign w_len_clamped = (32'(w_hdr_len) > 32'(c_MAX_WORDS)) ? c_MAX_N
                                                              : ROM_ADDR_WIDTH'(w_hdr_len);

    always_comb begin
        rom_en_o   = 1'b0;
        rom_addr_o = '0;
        case (r_state)
            c_ST_HDR_RD: rom_en_o = 1'b1;
            c_ST_RD: begin
                rom_en_o   = 1'b1;
                rom_addr_o = w_k_next;
            end
`ifdef BOOT_CHECKSUM_EN
            c_ST_CK_RD: begin
                rom_en_o   = 1'b1;
                rom_addr_o = r_n + c_K_ONE;
            end
`endif
            default: ;
        endcase
    end

    // Write port is driven purely from registered state, so it is stable while gnt is low.
    assign instr_req_o    = (r_state == c_ST_WR);
    assign instr_we_o     = instr_req_o;
    assign instr_addr_o   = instr_req_o ? (INSTR_BASE_ADDR + (32'(r_k) << 2)) : 32'h0;
    assign instr_wdata_o  = instr_req_o ? r_data : 32'h0;
    assign instr_be_o     = 4'hF;
    assign fetch_enable_o = r_fetch_en;
    assign boot_addr_o    = r_boot_addr;
    assign error_o        = r_err;
    assign words_copied_o = r_words;
    assign busy_o         = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE) &&
                            (r_state != c_ST_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_hdr       <= '0;
            r_data      <= '0;
            r_k         <= '0;
            r_n         <= '0;
            r_words     <= '0;
            r_fetch_en  <= 1'b0;
            r_err       <= 1'b0;
            r_boot_addr <= FALLBACK_BOOT_ADDR;
`ifdef BOOT_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (AUTO_START || start_i) r_state <= c_ST_HDR_RD;
                end
                c_ST_HDR_RD:  r_state <= c_ST_HDR_CAP;
                c_ST_HDR_CAP: begin
                    r_hdr   <= rom_rdata_i;
                    r_state <= c_ST_HDR_CHK;
                end
                c_ST_HDR_CHK: begin
                    if (w_hdr_bad) begin
                        r_state     <= c_ST_ERROR;
                        r_err       <= 1'b1;
                        r_fetch_en  <= 1'b1;
                        r_boot_addr <= FALLBACK_BOOT_ADDR;
                    end else begin
                        r_n     <= w_len_clamped;
                        r_k     <= '0;
                        r_state <= c_ST_RD;
                    end
                end
                c_ST_RD:  r_state <= c_ST_CAP;
                c_ST_CAP: begin
                    r_data  <= rom_rdata_i;
                    r_state <= c_ST_WR;
                end
                c_ST_WR: begin
                    if (instr_gnt_i) begin
                        r_words <= r_words + 16'd1;
                        r_k     <= w_k_next;
`ifdef BOOT_CHECKSUM_EN
                        r_csum  <= r_csum ^ r_data;
`endif
                        if (w_k_next < r_n) begin
                            r_state <= c_ST_RD;
                        end else begin
`ifdef BOOT_CHECKSUM_EN
                            r_state <= c_ST_CK_RD;
`else
                            r_state     <= c_ST_DONE;
                            r_fetch_en  <= 1'b1;
                            r_boot_addr <= INSTR_BASE_ADDR;
`endif
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                c_ST_CK_RD:  r_state <= c_ST_CK_CAP;
                c_ST_CK_CAP: begin
                    r_data  <= rom_rdata_i;
                    r_state <= c_ST_CK_CHK;
                end
                c_ST_CK_CHK: begin
                    r_fetch_en <= 1'b1;
                    if (r_data == r_csum) begin
                        r_state     <= c_ST_DONE;
                        r_boot_addr <= INSTR_BASE_ADDR;
                    end else begin
                        r_state     <= c_ST_ERROR;
                        r_err       <= 1'b1;
                        r_boot_addr <= FALLBACK_BOOT_ADDR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_boot_rom_copier.sv
//==============================================================================
// Module   : tb_boot_rom_copier
// Desc     : Self-checking bench for boot_rom_copier: vector table, directed
//            reset/clamp/checksum sequences and randomized images.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_boot_rom_copier;

`ifdef BOOT_CHECKSUM_EN
    localparam int c_MAX_WORDS = 4094;
    localparam int c_CK_CYC    = 3;
`else
    localparam int c_MAX_WORDS = 4095;
    localparam int c_CK_CYC    = 0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] hdr;
        int          gmode;
        bit          exp_err;
        int          exp_n;
        logic [31:0] exp_boot;
        int          exp_fe;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        rom_en_o;
    logic [11:0] rom_addr_o;
    logic [31:0] rom_rdata_i = 32'h0;
    logic        instr_req_o;
    logic        instr_we_o;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_wdata_o;
    logic [3:0]  instr_be_o;
    logic        instr_gnt_i = 1'b1;
    logic        fetch_enable_o;
    logic [31:0] boot_addr_o;
    logic        busy_o;
    logic        error_o;
    logic [15:0] words_copied_o;

    boot_rom_copier dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .rom_en_o       (rom_en_o),
        .rom_addr_o     (rom_addr_o),
        .rom_rdata_i    (rom_rdata_i),
        .instr_req_o    (instr_req_o),
        .instr_we_o     (instr_we_o),
        .instr_addr_o   (instr_addr_o),
        .instr_wdata_o  (instr_wdata_o),
        .instr_be_o     (instr_be_o),
        .instr_gnt_i    (instr_gnt_i),
        .fetch_enable_o (fetch_enable_o),
        .boot_addr_o    (boot_addr_o),
        .busy_o         (busy_o),
        .error_o        (error_o),
        .words_copied_o (words_copied_o)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:4095];
    wr_t         exp_q[$];
    wr_t         got_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          gnt_mode = 0;
    int          cyc = 0;
    int          hdr_cyc = 0;
    int          fe_cyc = 0;
    int          stall_cnt = 0;
    bit          hdr_seen = 0;
    bit          fe_seen = 0;
    bit          prev_wait = 0;
    logic [31:0] prev_addr = 0;
    logic [31:0] prev_data = 0;
    bit          rd_pend = 0;
    logic [11:0] rd_addr = 0;
    bit          m_err;
    bit          m_hdr_bad;
    int          m_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: what the loader should do with the current ROM image.
    task automatic model_run();
        logic [31:0] hdr;
        int          len;
`ifdef BOOT_CHECKSUM_EN
        logic [31:0] x;
        x = 32'h0;
`endif
        hdr = rom[0];
        len = int'(hdr[15:0]);
        exp_q.delete();
        m_n       = 0;
        m_hdr_bad = (hdr[31:16] != 16'hB007) || (len == 0);
        m_err     = m_hdr_bad;
        if (!m_hdr_bad) begin
            m_n = (len > c_MAX_WORDS) ? c_MAX_WORDS : len;
            for (int k = 0; k < m_n; k++) begin
                exp_q.push_back(wr_t'{32'(4 * k), rom[k + 1]});
`ifdef BOOT_CHECKSUM_EN
                x = x ^ rom[k + 1];
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            if (rom[m_n + 1] != x) m_err = 1'b1;
`endif
        end
    endtask

    task automatic set_checksum(input bit corrupt);
`ifdef BOOT_CHECKSUM_EN
        logic [31:0] x;
        model_run();
        if (!m_hdr_bad) begin
            x = 32'h0;
            foreach (exp_q[i]) x = x ^ exp_q[i].data;
            rom[m_n + 1] = corrupt ? (x ^ 32'h1) : x;
        end
`else
        if (corrupt) rom[0] = rom[0];
`endif
    endtask

    task automatic fill_image(input logic [31:0] hdr);
        for (int i = 0; i < 4096; i++) rom[i] = 32'(i) * 32'h11;
        rom[0] = hdr;
        set_checksum(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rst.rom_en"},  32'(rom_en_o), 32'h0);
        check({tag, ".rst.rom_addr"}, 32'(rom_addr_o), 32'h0);
        check({tag, ".rst.req"},     32'(instr_req_o), 32'h0);
        check({tag, ".rst.we"},      32'(instr_we_o), 32'h0);
        check({tag, ".rst.addr"},    instr_addr_o, 32'h0);
        check({tag, ".rst.wdata"},   instr_wdata_o, 32'h0);
        check({tag, ".rst.be"},      32'(instr_be_o), 32'hF);
        check({tag, ".rst.fe"},      32'(fetch_enable_o), 32'h0);
        check({tag, ".rst.boot"},    boot_addr_o, 32'h8000);
        check({tag, ".rst.busy"},    32'(busy_o), 32'h0);
        check({tag, ".rst.err"},     32'(error_o), 32'h0);
        check({tag, ".rst.words"},   32'(words_copied_o), 32'h0);
    endtask

    task automatic apply_reset(input bit check_outputs, input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (check_outputs) check_reset_outputs(tag);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_fetch(input string tag);
        for (int c = 0; c < 20000; c++) begin
            if (fetch_enable_o) break;
            @(negedge clk);
        end
        n_cmp++;
        if (!fetch_enable_o) begin
            n_bad++;
            $display("FAIL %s.timeout: fetch_enable_o still 0 after 20000 cycles, expected 1", tag);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input bit exp_err, input int exp_n,
                                input logic [31:0] exp_boot, input int exp_fe, input bit add_stalls);
        int lat;
        check({tag, ".err"},   32'(error_o), 32'(exp_err));
        check({tag, ".fe"},    32'(fetch_enable_o), 32'h1);
        check({tag, ".boot"},  boot_addr_o, exp_boot);
        check({tag, ".words"}, 32'(words_copied_o), 32'(exp_n));
        check({tag, ".busy"},  32'(busy_o), 32'h0);
        lat = fe_cyc - hdr_cyc - (add_stalls ? stall_cnt : 0);
        check({tag, ".fe_cycle"}, 32'(lat), 32'(exp_fe));
        check({tag, ".n_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s.wr%0d.addr", tag, i), got_q[i].addr, exp_q[i].addr);
            check($sformatf("%s.wr%0d.data", tag, i), got_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic run_case(input string tag, input int gmode, input bit exp_err, input int exp_n,
                            input logic [31:0] exp_boot, input int exp_fe, input bit add_stalls,
                            input bit chk_rst);
        gnt_mode = gmode;
        model_run();
        apply_reset(chk_rst, tag);
        wait_fetch(tag);
        check_result(tag, exp_err, exp_n, exp_boot, exp_fe, add_stalls);
    endtask

    // Observer: write capture, stall accounting, port-protocol checks.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            got_q.delete();
            hdr_seen  = 0;
            fe_seen   = 0;
            stall_cnt = 0;
            prev_wait = 0;
        end else begin
            if (!hdr_seen && rom_en_o && rom_addr_o == 12'd0) begin
                hdr_seen = 1;
                hdr_cyc  = cyc;
            end
            if (!fe_seen && fetch_enable_o) begin
                fe_seen = 1;
                fe_cyc  = cyc;
            end
            if (prev_wait) begin
                check("held.req",   32'(instr_req_o), 32'h1);
                check("held.addr",  instr_addr_o, prev_addr);
                check("held.wdata", instr_wdata_o, prev_data);
            end
            if (rom_en_o || instr_req_o) check("rom_ram_exclusive", 32'(rom_en_o & instr_req_o), 32'h0);
            if (instr_req_o) begin
                check("we", 32'(instr_we_o), 32'h1);
                check("be", 32'(instr_be_o), 32'hF);
                if (instr_gnt_i) got_q.push_back(wr_t'{instr_addr_o, instr_wdata_o});
                else stall_cnt++;
            end
            prev_wait = instr_req_o && !instr_gnt_i;
            prev_addr = instr_addr_o;
            prev_data = instr_wdata_o;
        end
        rd_pend = rom_en_o;
        rd_addr = rom_addr_o;
    end

    // ROM response, grant pattern and start_i noise, applied just after each edge.
    initial begin
        int  stall_left;
        bit  req_pending;
        stall_left  = 0;
        req_pending = 0;
        forever begin
            @(posedge clk); #1;
            rom_rdata_i = rd_pend ? rom[rd_addr] : $urandom();
            if (instr_req_o) begin
                if (!req_pending) begin
                    req_pending = 1;
                    stall_left  = (gnt_mode == 1) ? 2 : (gnt_mode == 2) ? int'($urandom_range(0, 3)) : 0;
                end
                if (stall_left > 0) begin
                    instr_gnt_i = 1'b0;
                    stall_left--;
                end else begin
                    instr_gnt_i = 1'b1;
                    req_pending = 0;
                end
            end else begin
                req_pending = 0;
                instr_gnt_i = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start_i = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        bit   found;
        int   len;
        vecs[0] = '{32'hB007_0004, 0, 1'b0, 4, 32'h0,    15 + c_CK_CYC};
        vecs[1] = '{32'hB007_0004, 1, 1'b0, 4, 32'h0,    23 + c_CK_CYC};
        vecs[2] = '{32'hDEAD_0004, 0, 1'b1, 0, 32'h8000, 3};
        vecs[3] = '{32'hB007_0000, 0, 1'b1, 0, 32'h8000, 3};
        vecs[4] = '{32'hB007_0001, 0, 1'b0, 1, 32'h0,    6 + c_CK_CYC};
        vecs[5] = '{32'hB006_0003, 1, 1'b1, 0, 32'h8000, 3};
        vecs[6] = '{32'hB007_0002, 1, 1'b0, 2, 32'h0,    13 + c_CK_CYC};

        for (int i = 0; i < 7; i++) begin
            fill_image(vecs[i].hdr);
            run_case($sformatf("vec%0d", i), vecs[i].gmode, vecs[i].exp_err, vecs[i].exp_n,
                     vecs[i].exp_boot, vecs[i].exp_fe, 1'b0, i == 0);
        end

        fill_image(32'hB007_FFFF);
        run_case("clamp", 0, 1'b0, c_MAX_WORDS, 32'h0, 3 + 3 * c_MAX_WORDS + c_CK_CYC, 1'b0, 1'b0);
        check("clamp.last_addr",
              (got_q.size() > 0) ? got_q[got_q.size() - 1].addr : 32'hFFFF_FFFF,
              32'(4 * (c_MAX_WORDS - 1)));

        // Reset while the third word is being written, then a clean restart.
        fill_image(32'hB007_0004);
        gnt_mode = 0;
        model_run();
        apply_reset(1'b0, "midrst");
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (instr_req_o && instr_addr_o == 32'h8) begin
                found = 1;
                break;
            end
        end
        check("midrst.reached_k2", 32'(found), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_fetch("midrst");
        check_result("midrst", 1'b0, 4, 32'h0, 15 + c_CK_CYC, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
        rom[0] = 32'hB007_0002;
        rom[1] = 32'h0000_000F;
        rom[2] = 32'h0000_00F0;
        rom[3] = 32'h0000_00FF;
        run_case("ck_good", 0, 1'b0, 2, 32'h0, 12, 1'b0, 1'b0);
        rom[3] = 32'h0000_00FE;
        run_case("ck_bad", 0, 1'b1, 2, 32'h8000, 12, 1'b0, 1'b0);
`endif

        for (int r = 0; r < 20; r++) begin
            for (int i = 1; i < 64; i++) rom[i] = $urandom();
            len = int'($urandom_range(1, 24));
            if ($urandom_range(0, 7) == 0) len = 0;
            rom[0] = {($urandom_range(0, 4) == 0) ? 16'($urandom()) : 16'hB007, 16'(len)};
            set_checksum($urandom_range(0, 3) == 0);
            model_run();
            run_case($sformatf("rnd%0d", r), 2, m_err, m_n, m_err ? 32'h8000 : 32'h0,
                     m_hdr_bad ? 3 : 3 + 3 * m_n + c_CK_CYC, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
